// File: rtl/gpio_in_conditioner.sv
// Pad input synchroniser, per-bit debounce filter and edge pulse generator
// feeding GPIOIN. Define GPIO_IN_IRQ_EN to build the sticky edge interrupt.
module gpio_in_conditioner #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT_W    = 8
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [WIDTH-1:0]    PIN_IN,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic [WIDTH-1:0]    irq_mask,
    input  logic [WIDTH-1:0]    irq_clr,
    output logic [WIDTH-1:0]    GPIOIN,
    output logic [WIDTH-1:0]    rise_pulse,
    output logic [WIDTH-1:0]    fall_pulse,
    output logic [WIDTH-1:0]    irq_status,
    output logic                IRQ
);

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [DB_CNT_W-1:0] cnt    [WIDTH];
    logic [WIDTH-1:0]    s;
    logic [WIDTH-1:0]    differ;
    logic [WIDTH-1:0]    expire;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain bringing the pads into the HCLK domain
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= PIN_IN;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // A bit flips once it has disagreed for db_limit+1 edges in a row
    always_comb begin
        differ = s ^ GPIOIN;
        expire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            expire[i] = differ[i] && (cnt[i] >= db_limit);
        end
    end

    // Stability counters; the >= compare keeps them from ever wrapping
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || expire[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Clean state plus edge pulses registered on the same edge
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            GPIOIN     <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            GPIOIN     <= GPIOIN ^ expire;
            rise_pulse <= expire & s;
            fall_pulse <= expire & ~s;
        end
    end

`ifdef GPIO_IN_IRQ_EN
    // Sticky edge flags; a new edge beats a coincident clear
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr)
                        | ((rise_pulse | fall_pulse) & irq_mask);
        end
    end

    assign IRQ = |irq_status;
`else
    logic unused_irq_in;

    assign unused_irq_in = ^{irq_mask, irq_clr};
    assign irq_status    = '0;
    assign IRQ           = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Randomised and directed bench for gpio_in_conditioner against a
// behavioural model of the debounce/edge/interrupt rules.
module tb_gpio_in_conditioner;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int DW = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [W-1:0]  PIN_IN;
    logic [DW-1:0] db_limit;
    logic [W-1:0]  irq_mask;
    logic [W-1:0]  irq_clr;
    logic [W-1:0]  GPIOIN;
    logic [W-1:0]  rise_pulse;
    logic [W-1:0]  fall_pulse;
    logic [W-1:0]  irq_status;
    logic          IRQ;

    int errors = 0;
    int checks = 0;

    // model state
    logic [W-1:0] sq[$];
    logic [W-1:0] m_g, m_rise, m_fall, m_irq;
    int           streak [W];

    gpio_in_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .DB_CNT_W(DW)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PIN_IN(PIN_IN),
        .db_limit(db_limit), .irq_mask(irq_mask), .irq_clr(irq_clr),
        .GPIOIN(GPIOIN), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .irq_status(irq_status), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        for (int k = 0; k < SS; k++) sq.push_back('0);
        m_g = '0; m_rise = '0; m_fall = '0; m_irq = '0;
        for (int i = 0; i < W; i++) streak[i] = 0;
    endtask

    // One rising edge: a bit's pad value reaches the filter SS edges later,
    // and the clean bit flips after db_limit+1 consecutive disagreements.
    task automatic model_edge();
        logic [W-1:0] s_used, g_old;
        s_used = sq.pop_front();
        sq.push_back(PIN_IN);
`ifdef GPIO_IN_IRQ_EN
        m_irq = (m_irq & ~irq_clr) | ((m_rise | m_fall) & irq_mask);
`endif
        g_old = m_g;
        for (int i = 0; i < W; i++) begin
            if (s_used[i] != m_g[i]) streak[i] = streak[i] + 1;
            else streak[i] = 0;
            if (streak[i] > int'(db_limit)) begin
                m_g[i] = s_used[i];
                streak[i] = 0;
            end
        end
        m_rise = m_g & ~g_old;
        m_fall = ~m_g & g_old;
    endtask

    task automatic compare_all();
        chk("gpioin", GPIOIN, m_g);
        chk("rise", rise_pulse, m_rise);
        chk("fall", fall_pulse, m_fall);
        chk("irq_status", irq_status, m_irq);
        chk("irq", IRQ, |m_irq);
    endtask

    task automatic tick();
        @(posedge HCLK);
        if (HRESETn) model_edge();
        @(negedge HCLK);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Cycles until GPIOIN[bit] equals val, bounded
    task automatic lat(input int b, input logic val, output int n);
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (GPIOIN[b] === val) begin
                n = k;
                break;
            end
        end
    endtask

    logic [W-1:0] exp3, exp2, exp0;
    logic         exp1;
    logic         acc;
    int           n;

    initial begin
`ifdef GPIO_IN_IRQ_EN
        exp3 = 16'h0003; exp2 = 16'h0002; exp1 = 1'b1;
`else
        exp3 = '0; exp2 = '0; exp1 = 1'b0;
`endif
        exp0 = '0;
        HRESETn = 1'b0;
        PIN_IN = 16'hFFFF;
        db_limit = 8'd3;
        irq_mask = '0;
        irq_clr = '0;
        model_reset();
        @(negedge HCLK);
        ticks(3);
        chk("reset_gpioin", GPIOIN, exp0);
        HRESETn = 1'b1;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (GPIOIN === 16'hFFFF) begin
                n = k;
                break;
            end
        end
        chk("reset_latency", n, 6);
        chk("reset_rise", rise_pulse, 16'hFFFF);
        tick();
        chk("reset_rise_1cyc", rise_pulse, exp0);

        PIN_IN = '0;
        ticks(10);
        PIN_IN[0] = 1'b1;
        lat(0, 1'b1, n);
        chk("db_latency", n, 6);
        PIN_IN[0] = 1'b0;
        ticks(10);
        PIN_IN[0] = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acc |= rise_pulse[0];
        end
        PIN_IN[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            acc |= rise_pulse[0] | GPIOIN[0];
        end
        chk("glitch", acc, 1'b0);

        db_limit = 8'd0;
        PIN_IN[5] = 1'b1;
        lat(5, 1'b1, n);
        chk("zero_latency", n, 3);
        for (int k = 0; k < 8; k++) begin
            PIN_IN[5] = ~PIN_IN[5];
            ticks(2);
        end
        ticks(4);

        db_limit = 8'd1;
        PIN_IN = '0;
        ticks(8);
        irq_mask = 16'h0003;
        PIN_IN[2:0] = 3'b111;
        ticks(10);
        chk("irq_set", irq_status, exp3);
        chk("irq_line", IRQ, exp1);
        irq_clr = 16'h0001;
        tick();
        irq_clr = '0;
        tick();
        chk("irq_clr", irq_status, exp2);
        irq_clr = 16'h0002;
        tick();
        irq_clr = '0;
        chk("irq_clr_all", irq_status, exp0);
        PIN_IN[1] = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (fall_pulse[1] === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("irq_edge_seen", n != 0, 1'b1);
        irq_clr = 16'h0002;
        tick();
        irq_clr = '0;
        chk("irq_set_wins", irq_status[1], exp1);
        ticks(3);

        irq_mask = '0;
        db_limit = 8'd3;
        PIN_IN = '0;
        ticks(12);
        PIN_IN[3] = 1'b1;
        ticks(4);
        HRESETn = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        HRESETn = 1'b1;
        lat(3, 1'b1, n);
        chk("midrst_latency", n, 6);

        for (int r = 0; r < 3000; r++) begin
            if (r % 200 == 0) begin
                db_limit = DW'($urandom_range(0, 5));
                irq_mask = W'($urandom);
            end
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 7) == 0) PIN_IN[i] = ~PIN_IN[i];
            end
            irq_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
